// File: rtl/pci_master_sched.sv
// pci_master_sched: round-robin owner selection for the shared PCI initiator, REQ#/GNT# handshake and latency-timer preemption.
module pci_master_sched #(
  parameter int NREQ = 4,
  parameter int OW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] int_req,
  input  logic [NREQ-1:0] int_last,
  input  logic            bus_master_en,
  input  logic [7:0]      lat_timer,
  input  logic            gnt,
  input  logic            frame_in,
  input  logic            irdy_in,
  output logic            req,
  output logic [NREQ-1:0] int_gnt,
  output logic [OW-1:0]   owner,
  output logic            int_preempt,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, REQUEST, OWN, RELEASE} state_t;
  state_t state, state_n;
  logic [OW-1:0] rr_ptr, rr_ptr_n, owner_n, win, owner_inc;
  logic [7:0] lat_cnt, lat_cnt_n;
  logic [1:0] rel_cnt, rel_cnt_n;
  logic [NREQ-1:0] int_gnt_n;
  logic req_n, preempt_n;
  // downward scan so the lowest offset from rr_ptr wins
  always_comb begin
    win = rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (int_req[OW'((int'(rr_ptr) + i) % NREQ)]) win = OW'((int'(rr_ptr) + i) % NREQ);
  end
  assign owner_inc = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
  always_comb begin
    state_n = state;
    req_n = req;
    int_gnt_n = int_gnt;
    owner_n = owner;
    preempt_n = int_preempt;
    rr_ptr_n = rr_ptr;
    lat_cnt_n = lat_cnt;
    rel_cnt_n = rel_cnt;
    case (state)
      IDLE: if (bus_master_en && |int_req) begin
        owner_n = win;
        req_n = 1'b0;
        state_n = REQUEST;
      end
      REQUEST: if (!int_req[owner] || !bus_master_en) begin
        req_n = 1'b1;
        state_n = IDLE;
      end else if (!gnt && frame_in && irdy_in) begin
        int_gnt_n = NREQ'(1) << owner;
        lat_cnt_n = lat_timer;
        state_n = OWN;
      end
      OWN: if (int_last[owner]) begin
        int_gnt_n = '0;
        req_n = 1'b1;
        preempt_n = 1'b0;
        rr_ptr_n = owner_inc;
        rel_cnt_n = 2'd1;
        state_n = RELEASE;
      end else begin
        lat_cnt_n = (lat_cnt == 8'd0) ? 8'd0 : lat_cnt - 8'd1;
        preempt_n = int_preempt | (lat_cnt == 8'd0 && gnt) | !bus_master_en;
      end
      RELEASE: begin
        rel_cnt_n = (rel_cnt == 2'd0) ? 2'd0 : rel_cnt - 2'd1;
        state_n = (rel_cnt <= 2'd1) ? IDLE : RELEASE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req <= 1'b1;
      int_gnt <= '0;
      owner <= '0;
      int_preempt <= 1'b0;
      rr_ptr <= '0;
      lat_cnt <= 8'd0;
      rel_cnt <= 2'd0;
    end else begin
      state <= state_n;
      req <= req_n;
      int_gnt <= int_gnt_n;
      owner <= owner_n;
      int_preempt <= preempt_n;
      rr_ptr <= rr_ptr_n;
      lat_cnt <= lat_cnt_n;
      rel_cnt <= rel_cnt_n;
    end
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_pci_master_sched.sv
// tb_pci_master_sched: directed-vector bench for pci_master_sched with NREQ=4.
module tb_pci_master_sched;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] int_req, int_last;
  logic bus_master_en;
  logic [7:0] lat_timer;
  logic gnt, frame_in, irdy_in;
  logic req, int_preempt, busy;
  logic [3:0] int_gnt;
  logic [1:0] owner;
  int checks = 0;
  int errors = 0;

  pci_master_sched #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .int_last(int_last),
    .bus_master_en(bus_master_en), .lat_timer(lat_timer), .gnt(gnt),
    .frame_in(frame_in), .irdy_in(irdy_in), .req(req), .int_gnt(int_gnt),
    .owner(owner), .int_preempt(int_preempt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; int_req = 4'b0; int_last = 4'b0; bus_master_en = 1'b1;
    lat_timer = 8'd20; gnt = 1'b1; frame_in = 1'b1; irdy_in = 1'b1;
    tick(); tick();
    chk("rst_req", req, 1); chk("rst_gnt", int_gnt, 0); chk("rst_owner", owner, 0);
    chk("rst_preempt", int_preempt, 0); chk("rst_busy", busy, 0);
    rst = 1'b0;
    // single requester
    int_req = 4'b0100;
    tick(); chk("single_req", req, 0); chk("single_owner", owner, 2); chk("single_busy", busy, 1);
    tick(); chk("single_nogrant", int_gnt, 0);
    gnt = 1'b0;
    tick(); chk("single_grant", int_gnt, 4'b0100);
    int_last = 4'b0100;
    tick(); chk("single_rel_gnt", int_gnt, 0); chk("single_rel_req", req, 1);
    int_last = 4'b0; int_req = 4'b0;
    tick(); chk("single_rel_req2", req, 1); chk("single_idle", busy, 0);
    // round-robin from a fresh reset
    rst = 1'b1; #1; rst = 1'b0;
    int_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(); chk("rr_owner", owner, k % 4); chk("rr_req", req, 0);
      tick(); chk("rr_grant", int_gnt, 4'b0001 << (k % 4));
      int_last = 4'b0001 << (k % 4);
      tick(); chk("rr_release", {int_gnt, req}, 5'b00001);
      int_last = 4'b0;
      tick(); chk("rr_hold_req", req, 1);
    end
    int_req = 4'b0;
    tick();
    // latency timer = 5, rr_ptr = 1 so requester 0 is found after wrapping
    lat_timer = 8'd5; int_req = 4'b0001;
    tick(); chk("lat_owner", owner, 0);
    tick(); chk("lat_grant", int_gnt, 4'b0001);
    gnt = 1'b1; lat_timer = 8'd200;
    for (int k = 1; k <= 6; k++) begin
      tick(); chk("lat_preempt", int_preempt, k == 6);
    end
    tick(); chk("lat_preempt_hold", int_preempt, 1); chk("lat_gnt_hold", int_gnt, 4'b0001);
    int_last = 4'b0001;
    tick(); chk("lat_preempt_clr", int_preempt, 0); chk("lat_gnt_clr", int_gnt, 0);
    int_last = 4'b0; int_req = 4'b0;
    tick();
    // latency timer = 0, preempt waits for gnt=1
    lat_timer = 8'd0; int_req = 4'b0010; gnt = 1'b0;
    tick(); chk("lat0_owner", owner, 1);
    tick(); chk("lat0_grant", int_gnt, 4'b0010);
    tick(); chk("lat0_no_preempt", int_preempt, 0);
    gnt = 1'b1;
    tick(); chk("lat0_preempt", int_preempt, 1);
    int_last = 4'b0010;
    tick(); int_last = 4'b0; int_req = 4'b0;
    tick();
    // withdrawal in REQUEST, rr_ptr = 2
    lat_timer = 8'd200; int_req = 4'b0001;
    tick(); chk("wd_owner", owner, 0); chk("wd_req", req, 0);
    int_req = 4'b0;
    tick(); chk("wd_req_high", req, 1); chk("wd_busy", busy, 0);
    int_req = 4'b1111;
    tick(); chk("wd_ptr_kept", owner, 2);
    int_req = 4'b0;
    tick(); chk("wd2_req_high", req, 1);
    // bus master disable during OWN
    int_req = 4'b0100;
    tick(); chk("dis_owner", owner, 2);
    gnt = 1'b0;
    tick(); chk("dis_grant", int_gnt, 4'b0100);
    bus_master_en = 1'b0;
    tick(); chk("dis_preempt", int_preempt, 1); chk("dis_gnt_kept", int_gnt, 4'b0100);
    int_req = 4'b0; bus_master_en = 1'b1;
    tick(); chk("dis_sticky", int_preempt, 1); chk("dis_req_drop_ign", int_gnt, 4'b0100);
    int_last = 4'b0001;
    tick(); chk("dis_nonowner_last", int_gnt, 4'b0100);
    int_last = 4'b0100;
    tick(); chk("dis_end_gnt", int_gnt, 0); chk("dis_end_preempt", int_preempt, 0);
    int_last = 4'b0;
    tick();
    // bus busy wait, rr_ptr = 3
    int_req = 4'b1000; frame_in = 1'b0;
    tick(); chk("busy_owner", owner, 3);
    tick(); chk("busy_frame", int_gnt, 0);
    frame_in = 1'b1; irdy_in = 1'b0;
    tick(); chk("busy_irdy", int_gnt, 0);
    irdy_in = 1'b1;
    tick(); chk("busy_grant", int_gnt, 4'b1000);
    // asynchronous reset mid-OWN
    #2 rst = 1'b1;
    #1 chk("arst_state", {req, int_gnt, owner, int_preempt, busy}, 9'b1_0000_00_0_0);
    rst = 1'b0; int_req = 4'b1111;
    tick(); chk("arst_restart", owner, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
